// File: rtl/xor_stream_checksum.sv
// xor_stream_checksum: WIDTH-bit XOR reduction over a framed input stream.
// It accumulates every accepted word of a packet. On the last beat it loads
// the checksum, parity, length and error flags into result registers and
// presents them through a valid/ready handshake.
module xor_stream_checksum #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CHECK_MODE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_LAST,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_SUM,
    output logic             OUT_PARITY,
    output logic [LEN_W-1:0] OUT_LEN,
    output logic             OUT_OVF,
    output logic             OUT_MISMATCH
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               par_q, par_d;
    logic [LEN_W-1:0]   olen_q, olen_d;
    logic               oovf_q, oovf_d;
    logic               mis_q, mis_d;

    // Values the accumulator would take if the current beat were accepted
    logic               beat;
    logic               len_sat;
    logic [WIDTH-1:0]   acc_inc;
    logic [LEN_W-1:0]   len_inc;
    logic               ovf_inc;
    logic               mode_inc;

    assign beat     = IN_VALID & (state_q == ST_ACCUM);
    assign len_sat  = (len_q == LEN_MAX);
    assign acc_inc  = acc_q ^ IN_DATA;
    assign len_inc  = len_sat ? len_q : len_q + LEN_W'(1);
    assign ovf_inc  = ovf_q | len_sat;
    assign mode_inc = (len_q == '0) ? CHECK_MODE : mode_q;

    // Ready/valid are pure state decodes, so no combinational path from OUT_READY
    assign IN_READY     = (state_q == ST_ACCUM);
    assign OUT_VALID    = (state_q == ST_HOLD);
    assign OUT_SUM      = sum_q;
    assign OUT_PARITY   = par_q;
    assign OUT_LEN      = olen_q;
    assign OUT_OVF      = oovf_q;
    assign OUT_MISMATCH = mis_q;

    // Next-state logic: accumulate in ACCUM, hold the result until it is taken
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        sum_d   = sum_q;
        par_d   = par_q;
        olen_d  = olen_q;
        oovf_d  = oovf_q;
        mis_d   = mis_q;

        case (state_q)
            ST_ACCUM: begin
                if (beat) begin
                    acc_d  = acc_inc;
                    len_d  = len_inc;
                    ovf_d  = ovf_inc;
                    mode_d = mode_inc;
                    if (IN_LAST) begin
                        sum_d   = acc_inc;
                        par_d   = ^acc_inc;
                        olen_d  = len_inc;
                        oovf_d  = ovf_inc;
                        mis_d   = mode_inc & (acc_inc != '0);
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (OUT_READY) begin
                    acc_d   = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            mode_q  <= 1'b0;
            sum_q   <= '0;
            par_q   <= 1'b0;
            olen_q  <= '0;
            oovf_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
            sum_q   <= sum_d;
            par_q   <= par_d;
            olen_q  <= olen_d;
            oovf_q  <= oovf_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Testbench for xor_stream_checksum (WIDTH=8, MAX_LEN=4): a table of directed
// packets plus hand sequences for back-pressure, reset and random traffic.
module tb_xor_stream_checksum;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic             CLK = 1'b0;
    logic             RST;
    logic             CHECK_MODE;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_LAST;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_SUM;
    logic             OUT_PARITY;
    logic [LEN_W-1:0] OUT_LEN;
    logic             OUT_OVF;
    logic             OUT_MISMATCH;

    int n_checks = 0;
    int n_fail   = 0;

    xor_stream_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .CLK(CLK), .RST(RST), .CHECK_MODE(CHECK_MODE),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_SUM(OUT_SUM),
        .OUT_PARITY(OUT_PARITY), .OUT_LEN(OUT_LEN), .OUT_OVF(OUT_OVF),
        .OUT_MISMATCH(OUT_MISMATCH)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic            mode;
        int              n;
        logic [5:0][7:0] w;
        bit              gaps;
        logic [7:0]      sum;
        logic            par;
        logic [2:0]      len;
        logic            ovf;
        logic            mis;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one packet; CHECK_MODE is inverted after the first beat so the latch is exercised
    task automatic send_pkt(input logic mode, input int n, input logic [5:0][7:0] w, input bit gaps, input int tag);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                IN_VALID = 1'b0;
                IN_DATA  = 8'hFF;
                IN_LAST  = 1'b1;
                tick();
            end
            IN_VALID   = 1'b1;
            IN_DATA    = w[i];
            IN_LAST    = (i == n - 1);
            CHECK_MODE = (i == 0) ? mode : ~mode;
            begin
                int t = 0;
                while (!IN_READY && t < 50) begin
                    tick();
                    t++;
                end
                if (t >= 50) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL in_ready_timeout[%0d]: got 0 expected 1", tag);
                end
            end
            tick();
        end
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    task automatic check_result(input int tag, input logic [7:0] sum, input logic par,
                                input logic [2:0] len, input logic ovf, input logic mis);
        check("out_valid", tag, 32'(OUT_VALID), 32'd1);
        check("in_ready_hold", tag, 32'(IN_READY), 32'd0);
        check("sum", tag, 32'(OUT_SUM), 32'(sum));
        check("parity", tag, 32'(OUT_PARITY), 32'(par));
        check("len", tag, 32'(OUT_LEN), 32'(len));
        check("ovf", tag, 32'(OUT_OVF), 32'(ovf));
        check("mismatch", tag, 32'(OUT_MISMATCH), 32'(mis));
    endtask

    task automatic take_result(input int tag);
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("valid_drop", tag, 32'(OUT_VALID), 32'd0);
        check("in_ready_back", tag, 32'(IN_READY), 32'd1);
    endtask

    initial begin
        logic [5:0][7:0] w;
        RST = 1'b1; CHECK_MODE = 1'b0; IN_VALID = 1'b0; IN_DATA = '0;
        IN_LAST = 1'b0; OUT_READY = 1'b0;

        vecs[0] = '{mode:1'b0, n:3, w:{8'h00, 8'h00, 8'h00, 8'h0F, 8'h34, 8'h12}, gaps:1'b0,
                    sum:8'h29, par:1'b1, len:3'd3, ovf:1'b0, mis:1'b0};
        vecs[1] = '{mode:1'b1, n:3, w:{8'h00, 8'h00, 8'h00, 8'hFF, 8'h5A, 8'hA5}, gaps:1'b1,
                    sum:8'h00, par:1'b0, len:3'd3, ovf:1'b0, mis:1'b0};
        vecs[2] = '{mode:1'b1, n:3, w:{8'h00, 8'h00, 8'h00, 8'hFE, 8'h5A, 8'hA5}, gaps:1'b0,
                    sum:8'h01, par:1'b1, len:3'd3, ovf:1'b0, mis:1'b1};
        vecs[3] = '{mode:1'b0, n:5, w:{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01}, gaps:1'b1,
                    sum:8'h01, par:1'b1, len:3'd4, ovf:1'b1, mis:1'b0};
        vecs[4] = '{mode:1'b0, n:1, w:{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80}, gaps:1'b0,
                    sum:8'h80, par:1'b1, len:3'd1, ovf:1'b0, mis:1'b0};
        vecs[5] = '{mode:1'b1, n:1, w:{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, gaps:1'b0,
                    sum:8'h00, par:1'b0, len:3'd1, ovf:1'b0, mis:1'b0};
        vecs[6] = '{mode:1'b1, n:2, w:{8'h00, 8'h00, 8'h00, 8'h00, 8'h3D, 8'h3C}, gaps:1'b1,
                    sum:8'h01, par:1'b1, len:3'd2, ovf:1'b0, mis:1'b1};
        vecs[7] = '{mode:1'b0, n:4, w:{8'h00, 8'h00, 8'h55, 8'hAA, 8'h0F, 8'hF0}, gaps:1'b0,
                    sum:8'h00, par:1'b0, len:3'd4, ovf:1'b0, mis:1'b0};
        vecs[8] = '{mode:1'b1, n:6, w:{8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}, gaps:1'b1,
                    sum:8'h3F, par:1'b0, len:3'd4, ovf:1'b1, mis:1'b1};

        // Reset state
        tick(); tick();
        RST = 1'b0;
        check("rst_in_ready", 0, 32'(IN_READY), 32'd1);
        check("rst_out_valid", 0, 32'(OUT_VALID), 32'd0);
        check("rst_sum", 0, 32'(OUT_SUM), 32'd0);
        check("rst_parity", 0, 32'(OUT_PARITY), 32'd0);
        check("rst_len", 0, 32'(OUT_LEN), 32'd0);
        check("rst_ovf", 0, 32'(OUT_OVF), 32'd0);
        check("rst_mismatch", 0, 32'(OUT_MISMATCH), 32'd0);

        // Directed table; OUT_VALID must already be high one cycle after the last beat
        for (int v = 0; v < 9; v++) begin
            send_pkt(vecs[v].mode, vecs[v].n, vecs[v].w, vecs[v].gaps, v);
            check_result(v, vecs[v].sum, vecs[v].par, vecs[v].len, vecs[v].ovf, vecs[v].mis);
            take_result(v);
        end

        // Back-pressure: result held for 10 cycles while IN_VALID beats are offered
        w = '0; w[0] = 8'h11; w[1] = 8'h22;
        send_pkt(1'b0, 2, w, 1'b0, 100);
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 8'h77; IN_LAST = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_result(100 + c, 8'h33, 1'b0, 3'd2, 1'b0, 1'b0);
        end
        IN_VALID = 1'b0; IN_LAST = 1'b0;
        take_result(110);
        w = '0; w[0] = 8'h44;
        send_pkt(1'b0, 1, w, 1'b0, 111);
        check_result(111, 8'h44, 1'b0, 3'd1, 1'b0, 1'b0);
        take_result(111);

        // Reset mid-packet discards the partial packet
        IN_VALID = 1'b1; IN_DATA = 8'hFF; IN_LAST = 1'b0; CHECK_MODE = 1'b1;
        tick(); tick();
        IN_VALID = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_valid", 200, 32'(OUT_VALID), 32'd0);
        check("midrst_ready", 200, 32'(IN_READY), 32'd1);
        tick();
        check("midrst_valid2", 200, 32'(OUT_VALID), 32'd0);
        w = '0; w[0] = 8'h3C;
        send_pkt(1'b0, 1, w, 1'b0, 201);
        check_result(201, 8'h3C, 1'b0, 3'd1, 1'b0, 1'b0);
        take_result(201);

        // Random packets against a reference XOR model
        for (int p = 0; p < 200; p++) begin
            int n;
            int hold;
            logic mode;
            logic [7:0] s;
            n    = $urandom_range(1, MAX_LEN);
            mode = 1'($urandom_range(0, 1));
            s    = '0;
            w    = '0;
            for (int i = 0; i < n; i++) begin
                w[i] = 8'($urandom);
                s    = s ^ w[i];
            end
            send_pkt(mode, n, w, 1'($urandom_range(0, 1)), 1000 + p);
            hold = $urandom_range(0, 3);
            for (int c = 0; c < hold; c++) tick();
            check_result(1000 + p, s, ^s, 3'(n), 1'b0, mode & (s != 8'h00));
            take_result(1000 + p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
